// File: rtl/alu_issue_queue_if.sv
// Dispatch, result-broadcast and issue signals of the ALU issue queue.
// The slave modport is the queue itself; the master modport is whoever feeds and drains it.
interface alu_issue_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [3:0]            disp_alucontrol;
    logic [TAG_WIDTH-1:0]  disp_tag;
    logic                  disp_a_rdy;
    logic [DATA_WIDTH-1:0] disp_a_data;
    logic [TAG_WIDTH-1:0]  disp_a_tag;
    logic                  disp_b_rdy;
    logic [DATA_WIDTH-1:0] disp_b_data;
    logic [TAG_WIDTH-1:0]  disp_b_tag;

    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [DATA_WIDTH-1:0] issue_a;
    logic [DATA_WIDTH-1:0] issue_b;
    logic [3:0]            issue_alucontrol;
    logic [TAG_WIDTH-1:0]  issue_tag;
    logic [CW-1:0]         count;

    modport master (
        output disp_valid, disp_alucontrol, disp_tag,
        output disp_a_rdy, disp_a_data, disp_a_tag,
        output disp_b_rdy, disp_b_data, disp_b_tag,
        output cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_a, issue_b, issue_alucontrol, issue_tag, count
    );

    modport slave (
        input  disp_valid, disp_alucontrol, disp_tag,
        input  disp_a_rdy, disp_a_data, disp_a_tag,
        input  disp_b_rdy, disp_b_data, disp_b_tag,
        input  cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_a, issue_b, issue_alucontrol, issue_tag, count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing in-order-priority issue queue for a single ALU: operands wake up from the CDB,
// the oldest fully-ready entry is moved into a registered issue stage each cycle.
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_queue_if.slave io
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [3:0]            alu;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  a_rdy;
        logic [DATA_WIDTH-1:0] a_data;
        logic [TAG_WIDTH-1:0]  a_tag;
        logic                  b_rdy;
        logic [DATA_WIDTH-1:0] b_data;
        logic [TAG_WIDTH-1:0]  b_tag;
    } entry_t;

    // Shared by stored-entry wakeup and dispatch bypass: a ready operand never looks at the CDB.
    function automatic entry_t wake(input entry_t e, input logic cv,
                                    input logic [TAG_WIDTH-1:0] ct, input logic [DATA_WIDTH-1:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.a_rdy && (e.a_tag == ct)) begin
            r.a_rdy  = 1'b1;
            r.a_data = cd;
        end
        if (cv && !e.b_rdy && (e.b_tag == ct)) begin
            r.b_rdy  = 1'b1;
            r.b_data = cd;
        end
        return r;
    endfunction

    entry_t                entry_q [DEPTH];
    entry_t                entry_d [DEPTH];
    entry_t                woke    [DEPTH+1];
    entry_t                disp_raw;
    entry_t                disp_entry;
    logic [DEPTH-1:0]      elig;
    logic [CW-1:0]         count_q, count_d, count_after;
    logic                  issue_valid_q, issue_valid_d;
    logic [DATA_WIDTH-1:0] issue_a_q, issue_a_d, issue_b_q, issue_b_d;
    logic [3:0]            issue_alu_q, issue_alu_d;
    logic [TAG_WIDTH-1:0]  issue_tag_q, issue_tag_d;
    logic                  disp_ready;
    logic                  can_select, any_elig, do_issue, do_disp;
    logic [IW-1:0]         sel_idx;

    assign disp_ready = (count_q < CW'(DEPTH));

    assign disp_raw = '{alu: io.disp_alucontrol, tag: io.disp_tag,
                        a_rdy: io.disp_a_rdy, a_data: io.disp_a_data, a_tag: io.disp_a_tag,
                        b_rdy: io.disp_b_rdy, b_data: io.disp_b_data, b_tag: io.disp_b_tag};
    assign disp_entry = wake(disp_raw, io.cdb_valid, io.cdb_tag, io.cdb_data);

    // Eligibility uses the registered operand state; a CDB hit this cycle only counts next cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign woke[gi] = wake(entry_q[gi], io.cdb_valid, io.cdb_tag, io.cdb_data);
            assign elig[gi] = (CW'(gi) < count_q) && entry_q[gi].a_rdy && entry_q[gi].b_rdy;
        end
    endgenerate
    assign woke[DEPTH] = '0;

    always_comb begin
        can_select    = !issue_valid_q || io.issue_ready;
        any_elig      = 1'b0;
        sel_idx       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                sel_idx  = IW'(i);
            end
        end
        do_issue      = can_select && any_elig;
        do_disp       = io.disp_valid && disp_ready;
        count_after   = count_q - CW'(do_issue);
        count_d       = count_after + CW'(do_disp);

        // Collapse over the selected slot, then append the dispatch at the first free slot.
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = '0;
            if (CW'(i) < count_after)
                entry_d[i] = (do_issue && (i >= int'(sel_idx))) ? woke[i+1] : woke[i];
            if (do_disp && (CW'(i) == count_after))
                entry_d[i] = disp_entry;
        end

        issue_valid_d = issue_valid_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_alu_d   = issue_alu_q;
        issue_tag_d   = issue_tag_q;
        if (do_issue) begin
            issue_valid_d = 1'b1;
            issue_a_d     = entry_q[sel_idx].a_data;
            issue_b_d     = entry_q[sel_idx].b_data;
            issue_alu_d   = entry_q[sel_idx].alu;
            issue_tag_d   = entry_q[sel_idx].tag;
        end else if (can_select) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_alu_q   <= '0;
            issue_tag_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_alu_q   <= issue_alu_d;
            issue_tag_q   <= issue_tag_d;
        end
    end

    assign io.disp_ready       = disp_ready;
    assign io.count            = count_q;
    assign io.issue_valid      = issue_valid_q;
    assign io.issue_a          = issue_a_q;
    assign io.issue_b          = issue_b_q;
    assign io.issue_alucontrol = issue_alu_q;
    assign io.issue_tag        = issue_tag_q;
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, physical destination/source tag width.
REQ-003 SHALL have parameter DEPTH, default 4, number of queue entries.
REQ-004 SHALL have one clock and a synchronous active-high reset, ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have the dispatch handshake: disp_valid input 1; disp_ready output 1.
REQ-006 SHALL have the dispatch payload: disp_alucontrol input 4; disp_tag input TAG_WIDTH (destination tag).
REQ-007 SHALL have dispatch operand A: disp_a_rdy input 1; disp_a_data input DATA_WIDTH; disp_a_tag input TAG_WIDTH.
REQ-008 SHALL have dispatch operand B: disp_b_rdy, disp_b_data, disp_b_tag, with the same widths and meanings as operand A.
REQ-009 SHALL have the result broadcast (CDB) inputs: cdb_valid 1; cdb_tag TAG_WIDTH; cdb_data DATA_WIDTH.
REQ-010 SHALL have the issue handshake: issue_valid output 1; issue_ready input 1 (ALU stage accepts).
REQ-011 SHALL have the issue payload outputs: issue_a DATA_WIDTH; issue_b DATA_WIDTH; issue_alucontrol 4; issue_tag TAG_WIDTH.
REQ-012 SHALL have output count, clog2(DEPTH)+1 bits, giving the number of occupied entries.

Function
REQ-013 Storage SHALL be a collapsing queue: entry 0 oldest; occupied entries contiguous from 0 to count-1.
REQ-014 disp_ready SHALL be (count < DEPTH), from registered state only; a same-cycle issue SHALL NOT free space for a dispatch.
REQ-015 Dispatch SHALL occur when disp_valid and disp_ready are both high; the payload is written at the first free slot after any same-cycle collapse.
REQ-016 Dispatch bypass: an operand with rdy=0 whose tag equals cdb_tag while cdb_valid is high SHALL be stored ready with cdb_data.
REQ-017 Wakeup: each cycle cdb_valid is high, every stored non-ready operand whose tag equals cdb_tag SHALL capture cdb_data and become ready; both operands of one entry may wake together.
REQ-018 An entry SHALL be eligible when both of its stored operands are ready at the start of the cycle; an operand woken this cycle is eligible next cycle.
REQ-019 Selection: the lowest-index eligible entry SHALL be chosen whenever the output register is empty or issue_ready is high.
REQ-020 The chosen entry SHALL be loaded into the issue output registers with issue_valid=1, removed from the queue, and the younger entries shifted down by one in the same edge.
REQ-021 Issue output hold: when issue_valid=1 and issue_ready=0, all issue_* outputs SHALL hold and no entry SHALL be selected.
REQ-022 When issue_ready=1 and no entry is eligible, issue_valid SHALL go to 0 at the next edge.
REQ-023 Minimum latency: a dispatch in cycle N with both operands ready SHALL produce issue_valid=1 at the edge ending cycle N+1.
REQ-024 disp_alucontrol SHALL pass unchanged (0 AND, 1 OR, 2 ADD, 6 SUB); other codes SHALL pass through without checking.
REQ-025 count SHALL equal the previous count, plus 1 on dispatch, minus 1 on selection; simultaneous dispatch and selection SHALL leave count unchanged.
REQ-026 A dispatch of an operand already ready SHALL ignore the CDB for that operand.
REQ-027 Behaviour when CDB tags are non-unique among waiting operands SHALL be that all matching operands capture.

Reset
REQ-028 When rst=1 at a clock edge, all entries SHALL be invalidated and the outputs SHALL become count=0, issue_valid=0, issue_a=0, issue_b=0, issue_alucontrol=0, issue_tag=0.
REQ-029 Reset SHALL override dispatch, wakeup and issue in the same cycle; in-flight entries SHALL be discarded.
REQ-030 disp_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-031 Ready dispatch: dispatch ADD a=5 b=7 tag=3, both ready, issue_ready=1 -> next cycle issue_valid=1, issue_a=5, issue_b=7, issue_alucontrol=2, issue_tag=3; count returns to 0.
REQ-032 Wakeup order: dispatch entry X (A waits on tag 9), then Y (ready); CDB tag=9 data=0x10 -> Y issues first, X issues next cycle with issue_a=0x10.
REQ-033 Bypass: dispatch SUB with A waiting on tag 2 while cdb_valid=1, tag=2, data=100 -> entry stored ready, issues next cycle with issue_a=100, issue_alucontrol=6.
REQ-034 Full and backpressure: issue_ready=0, 5 ready dispatches -> first issued and held, 4 stored, count=4, disp_ready=0; raise issue_ready -> issues in dispatch order, one per cycle.
REQ-035 Reset mid-operation: count=3 with issue_valid=1, assert rst one cycle -> count=0, issue_valid=0, disp_ready=1; a later CDB for the old tags causes no issue.
